clink_frame_tx: RTL and testbench
=================================

CLINK_FRAME_TX -- requirements
Module: clink_frame_tx

Interface
REQ-001 SHALL have parameter FV_SETUP, default 4: clocks with fval=1 and lval=0 before the first line.
REQ-002 SHALL have parameter H_BLANK, default 16: clocks with lval=0 between consecutive lines.
REQ-003 SHALL have parameter FV_HOLD, default 4: clocks with fval=1 and lval=0 after the last line.
REQ-004 SHALL have parameter V_BLANK, default 32: clocks with fval=0 after a frame, before the next start is accepted.
REQ-005 SHALL have port clk, input, 1 bit: single clock (pixel clock); all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request one frame; sampled each clock.
REQ-008 SHALL have port width, input, 12 bits: beats per line (1 beat = 3 pixels); latched on an accepted start.
REQ-009 SHALL have port height, input, 12 bits: lines per frame; latched on an accepted start.
REQ-010 SHALL have port s_pix_tdata, input, 24 bits: {d2,d1,d0}, 8 bits each.
REQ-011 SHALL have port s_pix_tvalid, input, 1 bit: pixel beat valid.
REQ-012 SHALL have port s_pix_tready, output, 1 bit: block accepts a beat.
REQ-013 SHALL have port tx_word, output, 28 bits: registered parallel word for the 7:1 serializer.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port frame_done, output, 1 bit: one-clock pulse at FV_HOLD to VBLANK.
REQ-016 SHALL have port underrun, output, 1 bit: one-clock pulse per stalled active beat.

Function
REQ-017 SHALL implement FSM states IDLE, FV_SETUP, LINE, HBLANK, FV_HOLD, VBLANK.
REQ-018 SHALL accept start only in IDLE with width!=0 and height!=0; otherwise start SHALL be ignored, with no state change.
REQ-019 SHALL transition IDLE->FV_SETUP (FV_SETUP clks)->LINE (width accepted beats)->HBLANK (H_BLANK clks)->LINE while lines remain.
REQ-020 SHALL, after the last line, go LINE->FV_HOLD directly (no HBLANK), then FV_HOLD (FV_HOLD clks)->VBLANK (V_BLANK clks)->IDLE.
REQ-021 SHALL drive s_pix_tready=1 only in LINE, decoded from state, not from s_pix_tvalid.
REQ-022 SHALL, in LINE: on tvalid&tready, advance the beat counter and set dval=1 with data = s_pix_tdata; on tvalid=0, hold the counter, drive dval=0 and data 0 with lval staying 1, and pulse underrun.
REQ-023 SHALL compute the tx_word field values as: fval=1 in FV_SETUP/LINE/HBLANK/FV_HOLD; lval=1 only in LINE; dval per REQ-022; all data 0 when dval=0.
REQ-024 SHALL register tx_word, so a beat accepted in cycle N appears on tx_word in cycle N+1; fval/lval track the state with the same one-cycle delay.
REQ-025 SHALL map tx_word bits as: d0[0..7]->bits 6,5,4,3,2,1,27,26; d1[0..7]->bits 0,13,12,11,10,9,25,24; d2[0..7]->bits 8,7,20,19,18,17,23,22.
REQ-026 SHALL map lval->bit 16, fval->bit 15, dval->bit 14, and drive spare bit 21=0.
REQ-027 SHALL use 12-bit beat and line counters and 16-bit blanking counters; a counter SHALL never wrap within a frame.
REQ-028 SHALL ignore start while busy, and SHALL ignore changes to width/height mid-frame.

Reset
REQ-029 SHALL, while rst_n=0 (immediately, asynchronously), force state=IDLE, tx_word=0, s_pix_tready=0, busy=0, frame_done=0, underrun=0, and counters=0.
REQ-030 SHALL, after reset is deasserted mid-frame, remain in IDLE until a new start, with no partial-frame resume.

Verification
REQ-031 SHALL be verified: width=4, height=2, tvalid constant 1, start pulse -> fval high 32 clks, two lval runs of 4 clks separated by 16, frame_done once, busy low 32 clks after frame_done.
REQ-032 SHALL be verified: beat {d2,d1,d0}=0x000001 accepted -> next tx_word=0x001C040; idle tx_word=0x0000000.
REQ-033 SHALL be verified: tvalid low 3 clks mid-line (width=4) -> lval run lasts 7 clks, dval=0 on 3 of them, underrun pulses 3 times.
REQ-034 SHALL be verified: start with height=0 or width=0 -> busy stays 0, tx_word stays 0; start while busy -> no second frame.
REQ-035 SHALL be verified: rst_n low during LINE -> tx_word=0 and tready=0 the same cycle; after release, stays IDLE until start.
REQ-036 SHALL be verified: walking-one across each of 24 data bits -> exactly the bit given in REQ-025 set, plus bits 14/15/16.

Source files
------------

// File: rtl/clink_frame_tx.sv
`timescale 1ns/1ps
// Camera Link base-configuration frame generator: sequences fval/lval/dval
// around an AXI-Stream pixel source and emits the registered 28-bit serializer word.
module clink_frame_tx #(
  parameter int unsigned FV_SETUP = 4,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned FV_HOLD  = 4,
  parameter int unsigned V_BLANK  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic [23:0] s_pix_tdata,
  input  logic        s_pix_tvalid,
  output logic        s_pix_tready,
  output logic [27:0] tx_word,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FV_SETUP,
    S_LINE,
    S_HBLANK,
    S_FV_HOLD,
    S_VBLANK
  } state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(FV_SETUP - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(FV_HOLD - 1);
  localparam logic [15:0] VBLANK_LAST = 16'(V_BLANK - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] beat_q, beat_d;
  logic [11:0] line_q, line_d;
  logic [11:0] w_q, w_d;
  logic [11:0] h_q, h_d;
  logic [27:0] word_q, word_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;

  logic        fval_c, lval_c, dval_c;
  logic [23:0] pix_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      w_q          <= '0;
      h_q          <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      w_q          <= w_d;
      h_q          <= h_d;
      word_q       <= word_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    line_d       = line_q;
    w_d          = w_q;
    h_d          = h_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (width != '0) && (height != '0)) begin
          w_d     = width;
          h_d     = height;
          cnt_d   = '0;
          state_d = S_FV_SETUP;
        end
      end
      S_FV_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          beat_d  = '0;
          line_d  = '0;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LINE: begin
        // Stalled beats hold the counter, so a line always carries exactly w_q valid beats.
        if (s_pix_tvalid) begin
          if (beat_q == w_q - 12'd1) begin
            beat_d = '0;
            cnt_d  = '0;
            if (line_q == h_q - 12'd1) begin
              state_d = S_FV_HOLD;
            end else begin
              line_d  = line_q + 12'd1;
              state_d = S_HBLANK;
            end
          end else begin
            beat_d = beat_q + 12'd1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == HBLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FV_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d        = '0;
          frame_done_d = 1'b1;
          state_d      = S_VBLANK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VBLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fval_c     = (state_q == S_FV_SETUP) || (state_q == S_LINE) ||
                 (state_q == S_HBLANK)   || (state_q == S_FV_HOLD);
    lval_c     = (state_q == S_LINE);
    dval_c     = lval_c && s_pix_tvalid;
    pix_c      = dval_c ? s_pix_tdata : '0;
    underrun_d = lval_c && !s_pix_tvalid;

    // Camera Link port A/B/C bit scatter onto the four 7-bit serializer lanes.
    word_d     = '0;
    word_d[6]  = pix_c[0];
    word_d[5]  = pix_c[1];
    word_d[4]  = pix_c[2];
    word_d[3]  = pix_c[3];
    word_d[2]  = pix_c[4];
    word_d[1]  = pix_c[5];
    word_d[27] = pix_c[6];
    word_d[26] = pix_c[7];
    word_d[0]  = pix_c[8];
    word_d[13] = pix_c[9];
    word_d[12] = pix_c[10];
    word_d[11] = pix_c[11];
    word_d[10] = pix_c[12];
    word_d[9]  = pix_c[13];
    word_d[25] = pix_c[14];
    word_d[24] = pix_c[15];
    word_d[8]  = pix_c[16];
    word_d[7]  = pix_c[17];
    word_d[20] = pix_c[18];
    word_d[19] = pix_c[19];
    word_d[18] = pix_c[20];
    word_d[17] = pix_c[21];
    word_d[23] = pix_c[22];
    word_d[22] = pix_c[23];
    word_d[16] = lval_c;
    word_d[15] = fval_c;
    word_d[14] = dval_c;
    word_d[21] = 1'b0;
  end

  assign s_pix_tready = (state_q == S_LINE);
  assign busy         = (state_q != S_IDLE);
  assign tx_word      = word_q;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_clink_frame_tx.sv
`timescale 1ns/1ps
// Self-checking bench for clink_frame_tx: scoreboard of expected serializer
// words generated from frame timing rules, plus directed corner cases.
module tb_clink_frame_tx;

  localparam int FVS = 4, HB = 16, FVH = 4, VB = 32;
  localparam logic [27:0] FV = 28'h0008000, LV = 28'h0010000, DV = 28'h0004000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] width = '0, height = '0;
  logic [23:0] s_pix_tdata = '0;
  logic        s_pix_tvalid = 1'b0;
  logic        s_pix_tready;
  logic [27:0] tx_word;
  logic        busy, frame_done, underrun;

  int checks = 0;
  int failures = 0;

  int D0[8] = '{6, 5, 4, 3, 2, 1, 27, 26};
  int D1[8] = '{0, 13, 12, 11, 10, 9, 25, 24};
  int D2[8] = '{8, 7, 20, 19, 18, 17, 23, 22};

  typedef struct {
    bit          v;
    logic [23:0] d;
    bit          in_line;
    logic [27:0] w;
    bit          ur;
    bit          fd;
  } ent_t;
  ent_t q[$];

  clink_frame_tx #(.FV_SETUP(FVS), .H_BLANK(HB), .FV_HOLD(FVH), .V_BLANK(VB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
    .s_pix_tdata(s_pix_tdata), .s_pix_tvalid(s_pix_tvalid), .s_pix_tready(s_pix_tready),
    .tx_word(tx_word), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] map_pix(input logic [23:0] d);
    logic [27:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      r[D0[k]] = d[k];
      r[D1[k]] = d[8 + k];
      r[D2[k]] = d[16 + k];
    end
    return r;
  endfunction

  function automatic void push(input bit v, input logic [23:0] d, input bit il,
                               input logic [27:0] w, input bit ur, input bit fd);
    ent_t e;
    e.v = v; e.d = d; e.in_line = il; e.w = w; e.ur = ur; e.fd = fd;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame, then replays the expected per-cycle stream while injecting
  // ignored mid-frame starts and width/height changes.
  task automatic run_frame(input int w, input int h, input int stall_pct, input bit walk,
                           output int fv_cnt, output int fd_cnt);
    int beats;
    logic [23:0] d;
    bit v;
    q.delete();
    for (int i = 0; i < FVS; i++) push(1'($urandom()), 24'($urandom()), 0, FV, 0, 0);
    for (int ln = 0; ln < h; ln++) begin
      beats = 0;
      while (beats < w) begin
        v = ($urandom_range(0, 99) >= stall_pct);
        d = walk ? (24'h1 << beats) : 24'($urandom());
        if (v) begin
          push(1, d, 1, FV | LV | DV | map_pix(d), 0, 0);
          beats++;
        end else begin
          push(0, d, 1, FV | LV, 1, 0);
        end
      end
      if (ln < h - 1)
        for (int i = 0; i < HB; i++) push(1'($urandom()), 24'($urandom()), 0, FV, 0, 0);
    end
    for (int i = 0; i < FVH; i++) push(1'($urandom()), 24'($urandom()), 0, FV, 0, i == FVH - 1);
    for (int i = 0; i < VB; i++) push(1'($urandom()), 24'($urandom()), 0, '0, 0, 0);

    fv_cnt = 0;
    fd_cnt = 0;
    width = 12'(w); height = 12'(h); start = 1'b1;
    tick();
    foreach (q[i]) begin
      start        = 1'($urandom());
      width        = 12'($urandom());
      height       = 12'($urandom());
      s_pix_tvalid = q[i].v;
      s_pix_tdata  = q[i].d;
      checks++;
      if (s_pix_tready !== q[i].in_line) begin
        failures++;
        $display("FAIL tready cyc=%0d got=%b exp=%b", i, s_pix_tready, q[i].in_line);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_frame cyc=%0d got=%b exp=1", i, busy);
      end
      tick();
      if (tx_word[15]) fv_cnt++;
      if (frame_done) fd_cnt++;
      checks++;
      if (tx_word !== q[i].w) begin
        failures++;
        $display("FAIL tx_word cyc=%0d got=%h exp=%h", i, tx_word, q[i].w);
      end
      checks++;
      if (underrun !== q[i].ur || frame_done !== q[i].fd) begin
        failures++;
        $display("FAIL ur_fd cyc=%0d got=%b%b exp=%b%b", i, underrun, frame_done, q[i].ur, q[i].fd);
      end
    end
    start = 1'b0;
    s_pix_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || tx_word !== '0) begin
        failures++;
        $display("FAIL post_frame_idle got busy=%b word=%h exp busy=0 word=0", busy, tx_word);
      end
      tick();
    end
  endtask

  task automatic wait_tready(input string tag);
    int n = 0;
    while (s_pix_tready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (s_pix_tready !== 1'b1) begin
      failures++;
      $display("FAIL %s_tready_timeout got=%b exp=1", tag, s_pix_tready);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout got busy=%b exp=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({tx_word, s_pix_tready, busy, frame_done, underrun} !== '0) begin
      failures++;
      $display("FAIL reset_state got word=%h rdy=%b busy=%b fd=%b ur=%b exp all 0",
               tx_word, s_pix_tready, busy, frame_done, underrun);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int fv, fd;
    run_frame(4, 2, 0, 0, fv, fd);
    checks++;
    if (fv != FVS + 4 * 2 + HB + FVH) begin
      failures++;
      $display("FAIL fval_len got=%0d exp=%0d", fv, FVS + 4 * 2 + HB + FVH);
    end
    checks++;
    if (fd != 1) begin
      failures++;
      $display("FAIL frame_done_count got=%0d exp=1", fd);
    end
  endtask

  task automatic test_single_beat();
    width = 12'd1; height = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tready("single");
    s_pix_tvalid = 1'b1; s_pix_tdata = 24'h000001;
    tick();
    s_pix_tvalid = 1'b0;
    checks++;
    if (tx_word !== 28'h001C040) begin
      failures++;
      $display("FAIL single_beat_word got=%h exp=001c040", tx_word);
    end
    wait_idle("single");
    checks++;
    if (tx_word !== 28'h0000000) begin
      failures++;
      $display("FAIL idle_word got=%h exp=0000000", tx_word);
    end
  endtask

  task automatic test_underrun();
    logic [6:0] pat = 7'b1110001;
    int lv = 0, dv0 = 0, ur = 0;
    width = 12'd4; height = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tready("underrun");
    for (int k = 0; k < 12; k++) begin
      s_pix_tvalid = (k < 7) ? pat[k] : 1'b0;
      s_pix_tdata  = 24'($urandom());
      tick();
      if (tx_word[16]) lv++;
      if (tx_word[16] && !tx_word[14]) dv0++;
      if (underrun) ur++;
    end
    checks++;
    if (lv != 7 || dv0 != 3 || ur != 3) begin
      failures++;
      $display("FAIL underrun_line got lval=%0d dval0=%0d ur=%0d exp 7/3/3", lv, dv0, ur);
    end
    wait_idle("underrun");
  endtask

  task automatic test_bad_start();
    logic [11:0] ws[2] = '{12'd0, 12'd5};
    logic [11:0] hs[2] = '{12'd3, 12'd0};
    for (int c = 0; c < 2; c++) begin
      width = ws[c]; height = hs[c]; start = 1'b1; s_pix_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (busy !== 1'b0 || tx_word !== '0) begin
          failures++;
          $display("FAIL bad_start case=%0d got busy=%b word=%h exp 0/0", c, busy, tx_word);
        end
      end
    end
    start = 1'b0; s_pix_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    width = 12'd3; height = 12'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tready("rstmid");
    s_pix_tvalid = 1'b1; s_pix_tdata = 24'hA5A5A5;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_word !== '0 || s_pix_tready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got word=%h rdy=%b busy=%b exp 0/0/0", tx_word, s_pix_tready, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || tx_word !== '0) begin
        failures++;
        $display("FAIL after_reset_idle cyc=%0d got busy=%b word=%h exp 0/0", i, busy, tx_word);
      end
    end
    s_pix_tvalid = 1'b0;
  endtask

  task automatic test_walking_one();
    int fv, fd;
    run_frame(24, 1, 20, 1, fv, fd);
  endtask

  task automatic test_random_frames();
    int fv, fd;
    for (int n = 0; n < 6; n++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 3), 30, 0, fv, fd);
    run_frame(1, 1, 0, 0, fv, fd);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_underrun();
    test_bad_start();
    test_reset_mid();
    test_walking_one();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
